// File: rtl/spi_req_arbiter_if.sv
// Bus bundle between the SPI request arbiter, its two requesters and the
// byte-level SPI shift engine. The slave modport is the arbiter's view; the
// master modport is the requester/engine side.
interface spi_req_arbiter_if #(
  parameter int N_CS  = 4,
  parameter int LEN_W = 8
);
  localparam int CSW = (N_CS > 1) ? $clog2(N_CS) : 1;

  logic             req0_i;
  logic             req1_i;
  logic [CSW-1:0]   csel0_i;
  logic [CSW-1:0]   csel1_i;
  logic [LEN_W-1:0] len0_i;
  logic [LEN_W-1:0] len1_i;
  logic [7:0]       txd0_i;
  logic [7:0]       txd1_i;
  logic             txv0_i;
  logic             txv1_i;
  logic             txrdy0_o;
  logic             txrdy1_o;
  logic             rxv0_o;
  logic             rxv1_o;
  logic             done0_o;
  logic             done1_o;
  logic [7:0]       rxd_o;
  logic [1:0]       gnt_o;
  logic             busy_o;
  logic             err_o;
  logic             eng_start_o;
  logic [7:0]       eng_txd_o;
  logic             eng_done_i;
  logic [7:0]       eng_rxd_i;
  logic [N_CS-1:0]  cs_n_o;

  modport slave (
    input  req0_i, req1_i, csel0_i, csel1_i, len0_i, len1_i,
    input  txd0_i, txd1_i, txv0_i, txv1_i, eng_done_i, eng_rxd_i,
    output txrdy0_o, txrdy1_o, rxv0_o, rxv1_o, done0_o, done1_o,
    output rxd_o, gnt_o, busy_o, err_o, eng_start_o, eng_txd_o, cs_n_o
  );

  modport master (
    output req0_i, req1_i, csel0_i, csel1_i, len0_i, len1_i,
    output txd0_i, txd1_i, txv0_i, txv1_i, eng_done_i, eng_rxd_i,
    input  txrdy0_o, txrdy1_o, rxv0_o, rxv1_o, done0_o, done1_o,
    input  rxd_o, gnt_o, busy_o, err_o, eng_start_o, eng_txd_o, cs_n_o
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI engine between two
// requesters. Owns chip-select setup/hold/gap timing and walks N bytes per
// grant through a start/done handshake with the engine.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction that
// stalls in FETCH/WAIT for TIMEOUT_CYC cycles (err_o pulses with done).
module spi_req_arbiter #(
  parameter int N_CS        = 4,
  parameter int LEN_W       = 8,
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               rst_n,
  spi_req_arbiter_if.slave  bus
);

  localparam int CSW    = (N_CS > 1) ? $clog2(N_CS) : 1;
  localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                          ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYC - 1);

  if (SETUP_CYC < 1 || HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_phase
    $error("spi_req_arbiter: SETUP_CYC, HOLD_CYC and GAP_CYC must be >= 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("spi_req_arbiter: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t           state;
  logic [PH_W-1:0]  cnt;
  logic             side;
  logic             ptr;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       gnt;
  logic [N_CS-1:0]  cs_n;
  logic [7:0]       rxd;
  logic             rxv0;
  logic             rxv1;
  logic             done0;
  logic             done1;
  logic             eng_start;
  logic [7:0]       eng_txd;

  logic             pick;
  logic [CSW-1:0]   csel_in;
  logic [LEN_W-1:0] len_in;
  logic [N_CS-1:0]  cs_dec;
  logic             txv_sel;
  logic [7:0]       txd_sel;
  logic             fetch_go;
  logic             wait_go;
  logic             hold_exit;
  logic             tmo_hit;

  // Grant choice: a lone request wins; with both pending the preferred side (ptr) wins.
  always_comb begin
    pick    = (bus.req0_i && bus.req1_i) ? ptr : bus.req1_i;
    csel_in = pick ? bus.csel1_i : bus.csel0_i;
    len_in  = pick ? bus.len1_i  : bus.len0_i;
    txv_sel = side ? bus.txv1_i  : bus.txv0_i;
    txd_sel = side ? bus.txd1_i  : bus.txd0_i;
  end

  // Chip-select decode; an index beyond N_CS drops no line but bytes still run.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (csel_in == CSW'(i)) cs_dec[i] = 1'b0;
    end
  end

  // Progress events that end a FETCH or WAIT cycle; engine done is ignored while start is high.
  always_comb begin
    fetch_go  = (state == S_FETCH) && txv_sel;
    wait_go   = (state == S_WAIT) && bus.eng_done_i && !eng_start;
    hold_exit = (state == S_HOLD) && (cnt == HOLD_LAST);
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo;
  logic             abort;
  logic             err;

  // Stall detector: counts cycles spent in one FETCH or WAIT visit.
  always_comb begin
    tmo_hit = (((state == S_FETCH) && !fetch_go) || ((state == S_WAIT) && !wait_go)) &&
              (tmo == TMO_W'(TIMEOUT_CYC - 1));
  end

  // Stall counter clears on every state change; an abort is flagged until HOLD ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo   <= '0;
      abort <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if ((state != S_FETCH && state != S_WAIT) || fetch_go || wait_go || tmo_hit) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + 1'b1;
      end
      if (tmo_hit) begin
        abort <= 1'b1;
      end else if (hold_exit) begin
        err   <= abort;
        abort <= 1'b0;
      end
    end
  end

  assign bus.err_o = err;
`else
  assign tmo_hit   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // Main sequencer: grant, CS setup, byte fetch/engine wait, CS hold and gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      side      <= 1'b0;
      ptr       <= 1'b0;
      remaining <= '0;
      gnt       <= 2'b00;
      cs_n      <= '1;
      rxd       <= 8'h00;
      rxv0      <= 1'b0;
      rxv1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      eng_start <= 1'b0;
      eng_txd   <= 8'h00;
    end else begin
      rxv0      <= 1'b0;
      rxv1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req0_i || bus.req1_i) begin
            side      <= pick;
            remaining <= len_in;
            cnt       <= '0;
            if (len_in == '0) begin
              done0 <= !pick;
              done1 <= pick;
              ptr   <= !pick;
              gnt   <= 2'b00;
              state <= S_GAP;
            end else begin
              gnt   <= pick ? 2'b10 : 2'b01;
              cs_n  <= cs_dec;
              state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= S_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_go) begin
            eng_txd   <= txd_sel;
            eng_start <= 1'b1;
            state     <= S_WAIT;
          end else if (tmo_hit) begin
            state <= S_HOLD;
          end
        end
        S_WAIT: begin
          if (wait_go) begin
            rxd       <= bus.eng_rxd_i;
            rxv0      <= !side;
            rxv1      <= side;
            remaining <= remaining - LEN_W'(1);
            state     <= (remaining == LEN_W'(1)) ? S_HOLD : S_FETCH;
          end else if (tmo_hit) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_exit) begin
            cnt   <= '0;
            cs_n  <= '1;
            done0 <= !side;
            done1 <= side;
            gnt   <= 2'b00;
            ptr   <= !side;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.txrdy0_o    = (state == S_FETCH) && !side;
  assign bus.txrdy1_o    = (state == S_FETCH) && side;
  assign bus.rxv0_o      = rxv0;
  assign bus.rxv1_o      = rxv1;
  assign bus.done0_o     = done0;
  assign bus.done1_o     = done1;
  assign bus.rxd_o       = rxd;
  assign bus.gnt_o       = gnt;
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.eng_start_o = eng_start;
  assign bus.eng_txd_o   = eng_txd;
  assign bus.cs_n_o      = cs_n;

endmodule
